// File: rtl/switch_allocator_pkg.sv
// Shared definitions for the 5-port router switch allocator.
package switch_allocator_pkg;

    localparam int NUM_PORTS = 5;

    // Port index constants, shared by inputs and outputs.
    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    // Per-output allocation state.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } out_state_e;

    // True when exactly one bit of a 5-bit vector is set.
    function automatic logic is_onehot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    // Index of the set bit of a one-hot vector (0 when empty).
    function automatic logic [2:0] onehot_to_idx(input logic [4:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (v[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_5.sv
// Combinational 5-input round-robin picker: first request at or above ptr, wrapping.
module rr_arbiter_5
    import switch_allocator_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] gnt
);

    logic [2:0] start;
    logic [3:0] pos;
    logic       found;

    // Scan from the pointer upward modulo 5 and take the first request.
    always_comb begin
        gnt   = 5'd0;
        found = 1'b0;
        pos   = 4'd0;
        // Out-of-range pointers cannot occur from the allocator; fold them to 0 anyway.
        start = (ptr > 3'd4) ? 3'd0 : ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            pos = {1'b0, start} + 4'(k);
            if (pos >= 4'd5) pos = pos - 4'd5;
            if (!found && req[pos[2:0]]) begin
                gnt[pos[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin with packet locking and credit tracking.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int unsigned P_BUFFER_DEPTH = 4,
    parameter int unsigned P_CREDIT_WIDTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req_0,
    input  logic [4:0] req_1,
    input  logic [4:0] req_2,
    input  logic [4:0] req_3,
    input  logic [4:0] req_4,
    input  logic [4:0] head,
    input  logic [4:0] tail,
    input  logic [4:0] credit_inc,
    output logic [4:0] grant_0,
    output logic [4:0] grant_1,
    output logic [4:0] grant_2,
    output logic [4:0] grant_3,
    output logic [4:0] grant_4,
    output logic [4:0] credit_avail
);

    localparam int unsigned CW = P_CREDIT_WIDTH;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(P_BUFFER_DEPTH);

    logic [4:0]    req_arr   [NUM_PORTS];
    logic [4:0]    req_valid;                 // per input
    out_state_e    state_q   [NUM_PORTS];
    out_state_e    state_d   [NUM_PORTS];
    logic [2:0]    owner_q   [NUM_PORTS];
    logic [2:0]    owner_d   [NUM_PORTS];
    logic [2:0]    ptr_q     [NUM_PORTS];
    logic [2:0]    ptr_d     [NUM_PORTS];
    logic [CW-1:0] cnt_q     [NUM_PORTS];
    logic [CW-1:0] cnt_d     [NUM_PORTS];
    logic [4:0]    elig      [NUM_PORTS];     // per output, bit per input
    logic [4:0]    out_gnt   [NUM_PORTS];     // per output, bit per input
    logic [4:0]    grant_q   [NUM_PORTS];     // per input, bit per output
    logic [4:0]    grant_d   [NUM_PORTS];

    assign req_arr[LOCAL] = req_0;
    assign req_arr[NORTH] = req_1;
    assign req_arr[EAST]  = req_2;
    assign req_arr[SOUTH] = req_3;
    assign req_arr[WEST]  = req_4;

    assign grant_0 = grant_q[LOCAL];
    assign grant_1 = grant_q[NORTH];
    assign grant_2 = grant_q[EAST];
    assign grant_3 = grant_q[SOUTH];
    assign grant_4 = grant_q[WEST];

    // Eligible requesters per output: heads when idle, only the owner when locked, none without credit.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_valid[i] = is_onehot5(req_arr[i]);
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            elig[o] = 5'd0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (state_q[o] == IDLE) begin
                    elig[o][i] = req_valid[i] & req_arr[i][o] & head[i];
                end else begin
                    elig[o][i] = req_valid[i] & req_arr[i][o] & (owner_q[o] == 3'(i));
                end
            end
            if (cnt_q[o] == '0) elig[o] = 5'd0;
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter_5 u_arb (
            .req (elig[o]),
            .ptr (ptr_q[o]),
            .gnt (out_gnt[o])
        );
    end

    logic          granted;
    logic [2:0]    win;
    logic          win_tail;
    logic [CW:0]   cnt_sum;

    // Next lock/owner/pointer/credit state per output and the transposed grant vectors.
    always_comb begin
        granted  = 1'b0;
        win      = 3'd0;
        win_tail = 1'b0;
        cnt_sum  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_d[i] = 5'd0;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            granted    = |out_gnt[o];
            win        = onehot_to_idx(out_gnt[o]);
            win_tail   = |(out_gnt[o] & tail);
            if (granted) begin
                if (state_q[o] == IDLE) begin
                    ptr_d[o] = (win == 3'd4) ? 3'd0 : win + 3'd1;
                    if (!win_tail) begin
                        state_d[o] = LOCKED;
                        owner_d[o] = win;
                    end
                end else if (win_tail) begin
                    state_d[o] = IDLE;
                end
            end
            // Grant implies cnt > 0, so the subtraction cannot wrap.
            cnt_sum = {1'b0, cnt_q[o]} + (CW + 1)'(credit_inc[o]) - (CW + 1)'(granted);
            if (cnt_sum > {1'b0, CREDIT_MAX}) begin
                cnt_d[o] = CREDIT_MAX;
            end else begin
                cnt_d[o] = cnt_sum[CW-1:0];
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                grant_d[i][o] = out_gnt[o][i];
            end
        end
    end

    // Credit availability straight from the counters.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            credit_avail[o] = (cnt_q[o] != '0);
        end
    end

    // State registers; reset clears locks and grants immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= 3'd0;
                ptr_q[o]   <= 3'd0;
                cnt_q[o]   <= CREDIT_MAX;
                grant_q[o] <= 5'd0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
                cnt_q[o]   <= cnt_d[o];
                grant_q[o] <= grant_d[o];
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: directed vectors, expected grants queued, monitor compares.
module tb_switch_allocator;

    localparam logic [4:0] Z  = 5'b00000;
    localparam logic [4:0] PL = 5'b00001;
    localparam logic [4:0] PN = 5'b00010;
    localparam logic [4:0] PE = 5'b00100;
    localparam logic [4:0] PS = 5'b01000;
    localparam logic [4:0] PW = 5'b10000;
    localparam logic [4:0] AA = 5'b11111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req_0 = '0, req_1 = '0, req_2 = '0, req_3 = '0, req_4 = '0;
    logic [4:0] head = '0, tail = '0, credit_inc = '0;
    logic [4:0] grant_0, grant_1, grant_2, grant_3, grant_4, credit_avail;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [24:0] g;
        logic [4:0]  avail;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    switch_allocator #(
        .P_BUFFER_DEPTH (4),
        .P_CREDIT_WIDTH (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_0        (req_0),
        .req_1        (req_1),
        .req_2        (req_2),
        .req_3        (req_3),
        .req_4        (req_4),
        .head         (head),
        .tail         (tail),
        .credit_inc   (credit_inc),
        .grant_0      (grant_0),
        .grant_1      (grant_1),
        .grant_2      (grant_2),
        .grant_3      (grant_3),
        .grant_4      (grant_4),
        .credit_avail (credit_avail)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] gv(input logic [4:0] g0, g1, g2, g3, g4);
        return {g4, g3, g2, g1, g0};
    endfunction

    // Monitor: grants are valid after each rising edge; compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({grant_4, grant_3, grant_2, grant_1, grant_0} !== mon_e.g ||
                credit_avail !== mon_e.avail) begin
                errors++;
                $display("FAIL %s: grants=%b avail=%b, expected grants=%b avail=%b", mon_e.name,
                         {grant_4, grant_3, grant_2, grant_1, grant_0}, credit_avail,
                         mon_e.g, mon_e.avail);
            end
        end
    end

    // Apply one cycle of stimulus at the falling edge and queue the response due after the next rise.
    task automatic drive(input string nm, input logic [4:0] r0, r1, r2, r3, r4,
                         input logic [4:0] h, t, ci, input logic [24:0] eg,
                         input logic [4:0] ea);
        exp_t e;
        @(negedge clk);
        req_0 = r0; req_1 = r1; req_2 = r2; req_3 = r3; req_4 = r4;
        head = h; tail = t; credit_inc = ci;
        e.name = nm; e.g = eg; e.avail = ea;
        exp_q.push_back(e);
    endtask

    task automatic direct_check(input string nm, input logic [4:0] ea);
        checks++;
        if ({grant_4, grant_3, grant_2, grant_1, grant_0} !== 25'd0 || credit_avail !== ea) begin
            errors++;
            $display("FAIL %s: grants=%b avail=%b, expected grants=0 avail=%b", nm,
                     {grant_4, grant_3, grant_2, grant_1, grant_0}, credit_avail, ea);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 direct_check("in_reset", AA);
        @(negedge clk);
        rst = 1'b0;
        #1 direct_check("after_reset", AA);

        // East: single-flit packets, pointer move, credit drain/return/saturation.
        drive("e_single",  PE, Z, Z, Z, Z, 5'b00001, 5'b00001, Z, gv(PE, Z, Z, Z, Z), AA);
        drive("idle",      Z,  Z, Z, Z, Z, Z, Z, Z, gv(Z, Z, Z, Z, Z), AA);
        drive("e_ptr1",    PE, Z, Z, PE, Z, 5'b01001, 5'b01001, Z, gv(Z, Z, Z, PE, Z), AA);
        drive("e_inc_gnt", PE, Z, Z, Z, Z, 5'b00001, 5'b00001, PE, gv(PE, Z, Z, Z, Z), AA);
        drive("e_drain1",  PE, Z, Z, Z, Z, 5'b00001, 5'b00001, Z, gv(PE, Z, Z, Z, Z), AA);
        drive("e_drain0",  PE, Z, Z, Z, Z, 5'b00001, 5'b00001, Z, gv(PE, Z, Z, Z, Z), 5'b11011);
        drive("e_nocred",  PE, Z, Z, Z, Z, 5'b00001, 5'b00001, Z, gv(Z, Z, Z, Z, Z), 5'b11011);
        for (int k = 0; k < 4; k++) begin
            drive("e_return", Z, Z, Z, Z, Z, Z, Z, PE, gv(Z, Z, Z, Z, Z), AA);
        end
        for (int k = 0; k < 3; k++) begin
            drive("e_sat", PE, Z, Z, Z, Z, 5'b00001, 5'b00001, Z, gv(PE, Z, Z, Z, Z), AA);
        end
        drive("e_sat_last", PE, Z, Z, Z, Z, 5'b00001, 5'b00001, Z, gv(PE, Z, Z, Z, Z), 5'b11011);
        drive("e_sat_none", PE, Z, Z, Z, Z, 5'b00001, 5'b00001, Z, gv(Z, Z, Z, Z, Z), 5'b11011);
        drive("e_restore",  Z,  Z, Z, Z, Z, Z, Z, PE, gv(Z, Z, Z, Z, Z), AA);

        // North: round-robin between competing heads, including 4 -> 0 wrap.
        drive("n_rr1", Z, PN, Z, PN, Z, 5'b01010, 5'b01010, PN, gv(Z, PN, Z, Z, Z), AA);
        drive("n_rr3", Z, PN, Z, PN, Z, 5'b01010, 5'b01010, PN, gv(Z, Z, Z, PN, Z), AA);
        drive("n_rr4", Z, PN, Z, Z, PN, 5'b10010, 5'b10010, PN, gv(Z, Z, Z, Z, PN), AA);
        drive("n_wrap", Z, PN, Z, Z, PN, 5'b10010, 5'b10010, PN, gv(Z, PN, Z, Z, Z), AA);

        // West: packet lock, owner stall, tail release, credit exhaustion.
        drive("w_head2",  Z, Z, PW, Z, PW, 5'b10100, Z, Z, gv(Z, Z, PW, Z, Z), AA);
        drive("w_body2",  Z, Z, PW, Z, PW, 5'b10000, Z, Z, gv(Z, Z, PW, Z, Z), AA);
        drive("w_stall",  Z, Z, Z, Z, PW, 5'b10000, Z, Z, gv(Z, Z, Z, Z, Z), AA);
        drive("w_tail2",  Z, Z, PW, Z, PW, 5'b10000, 5'b00100, PW, gv(Z, Z, PW, Z, Z), AA);
        drive("w_head4",  Z, Z, Z, Z, PW, 5'b10000, Z, Z, gv(Z, Z, Z, Z, PW), AA);
        drive("w_body4",  PW, Z, Z, Z, PW, 5'b00001, Z, Z, gv(Z, Z, Z, Z, PW), 5'b01111);
        drive("w_nocred", Z, Z, Z, Z, PW, Z, 5'b10000, PW, gv(Z, Z, Z, Z, Z), AA);
        drive("w_onecred", Z, Z, Z, Z, PW, Z, 5'b10000, Z, gv(Z, Z, Z, Z, PW), 5'b01111);
        drive("w_empty",  PW, Z, Z, Z, Z, 5'b00001, 5'b00001, Z, gv(Z, Z, Z, Z, Z), 5'b01111);
        drive("w_ret",    Z, Z, Z, Z, Z, Z, Z, PW, gv(Z, Z, Z, Z, Z), AA);
        drive("w_bodyidle", PW, Z, Z, Z, Z, Z, Z, Z, gv(Z, Z, Z, Z, Z), AA);
        drive("w_head0",  PW, Z, Z, Z, Z, 5'b00001, 5'b00001, Z, gv(PW, Z, Z, Z, Z), 5'b01111);
        drive("w_restore", Z, Z, Z, Z, Z, Z, Z, PW, gv(Z, Z, Z, Z, Z), AA);

        // Non-one-hot request is ignored and disturbs nothing.
        drive("x_multi", 5'b00011, Z, Z, Z, Z, 5'b00001, 5'b00001, Z, gv(Z, Z, Z, Z, Z), AA);
        drive("x_after", PN, PN, Z, Z, Z, 5'b00011, 5'b00011, Z, gv(PN, Z, Z, Z, Z), AA);

        // Lock South, then reset mid-packet.
        drive("s_lock", Z, PS, Z, Z, Z, 5'b00010, Z, Z, gv(Z, PS, Z, Z, Z), AA);
        @(negedge clk);
        req_0 = Z; req_1 = Z; req_2 = Z; req_3 = Z; req_4 = Z;
        head = Z; tail = Z; credit_inc = Z;
        #2 rst = 1'b1;
        #1 direct_check("rst_async", AA);
        @(negedge clk);
        rst = 1'b0;
        #1 direct_check("rst_release", AA);

        drive("s_unlocked", Z, PS, Z, PS, Z, 5'b01000, Z, Z, gv(Z, Z, Z, PS, Z), AA);
        drive("s_cred2", Z, Z, Z, PS, Z, Z, Z, Z, gv(Z, Z, Z, PS, Z), AA);
        drive("s_cred1", Z, Z, Z, PS, Z, Z, Z, Z, gv(Z, Z, Z, PS, Z), AA);
        drive("s_cred0", Z, Z, Z, PS, Z, Z, Z, Z, gv(Z, Z, Z, PS, Z), 5'b10111);
        drive("s_none",  Z, Z, Z, PS, Z, Z, Z, Z, gv(Z, Z, Z, Z, Z), 5'b10111);
        drive("quiet",   Z, Z, Z, Z, Z, Z, Z, Z, gv(Z, Z, Z, Z, Z), 5'b10111);

        // Wait for the monitor to drain the queue, with a bound.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
